// File: rtl/branch_resolve_unit_if.sv
// Purpose: bundles the fetch prediction, hazard controls, EX outcome and resolution outputs of the branch resolve unit.
// Latency: none; this is wiring only.
// Backpressure: none; stage holds travel as the StallF/StallD/StallE level signals.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  // Fetch-side prediction
  logic [31:0]      PCF;
  logic             pred_taken_F;
  logic [31:0]      pred_target_F;
  // Hazard unit controls
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  // Actual outcome of the EX instruction
  logic [2:0]       BranchTypeE;
  logic             BranchE;
  logic [31:0]      BranchTarget;
  // Recovery and predictor training
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush_req;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic             upd_taken;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output PCF, pred_taken_F, pred_target_F,
    output StallF, StallD, StallE, FlushD, FlushE,
    output BranchTypeE, BranchE, BranchTarget,
    input  redirect, redirect_pc, flush_req,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    input  br_cnt, miss_cnt
  );

  modport slave (
    input  PCF, pred_taken_F, pred_target_F,
    input  StallF, StallD, StallE, FlushD, FlushE,
    input  BranchTypeE, BranchE, BranchTarget,
    output redirect, redirect_pc, flush_req,
    output upd_valid, upd_pc, upd_target, upd_taken,
    output br_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Purpose: carries fetch predictions down to EX, detects mispredicts, redirects fetch and trains the predictor.
// Latency: prediction reaches EX after 2 un-stalled edges; redirect/update are combinational in the EX cycle.
// Backpressure: StallD/StallE hold their stage; a redirect raised while StallF=1 is held pending until fetch takes it.
module branch_resolve_unit #(
  parameter int CNT_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  branch_resolve_unit_if.slave  bus
);

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        ptaken;
    logic [31:0] ptarget;
  } stage_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t           d_q, d_d;
  stage_t           e_q, e_d;
  state_t           state_q;
  logic [31:0]      pend_pc_q;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             resolve;
  logic             is_br;
  logic             miss;
  logic [31:0]      pc_plus4;
  logic [31:0]      miss_tgt;
  logic             upd_vld;
  logic             redirect_w;

  // Next contents of the ID and EX prediction registers; stall beats flush.
  always_comb begin
    d_d = d_q;
    e_d = e_q;
    if (!bus.StallD) begin
      if (bus.FlushD) begin
        d_d = '0;
      end else begin
        d_d.vld     = 1'b1;
        d_d.pc      = bus.PCF;
        d_d.ptaken  = bus.pred_taken_F;
        d_d.ptarget = bus.pred_target_F;
      end
    end
    if (!bus.StallE) begin
      e_d = bus.FlushE ? '0 : d_q;
    end
  end

  // Compare the EX prediction against the real outcome and pick the corrected PC.
  always_comb begin
    resolve  = e_q.vld & ~bus.StallE;
    is_br    = (bus.BranchTypeE != 3'd0);
    pc_plus4 = e_q.pc + 32'd4;
    miss     = 1'b0;
    miss_tgt = pc_plus4;
    if (is_br) begin
      if (bus.BranchE && (!e_q.ptaken || (e_q.ptarget != bus.BranchTarget))) begin
        miss     = 1'b1;
        miss_tgt = bus.BranchTarget;
      end else if (!bus.BranchE && e_q.ptaken) begin
        miss     = 1'b1;
        miss_tgt = pc_plus4;
      end
    end else if (e_q.ptaken) begin
      // Predictor hit on a non-branch: fall through and untrain the alias.
      miss = 1'b1;
    end
    if (!resolve) begin
      miss = 1'b0;
    end
  end

  // Predictor write strobe and payload, zero when nothing resolves.
  always_comb begin
    upd_vld        = resolve & (is_br | e_q.ptaken);
    bus.upd_valid  = upd_vld;
    bus.upd_pc     = '0;
    bus.upd_target = '0;
    bus.upd_taken  = 1'b0;
    if (upd_vld) begin
      bus.upd_pc     = e_q.pc;
      bus.upd_taken  = is_br ? bus.BranchE : 1'b0;
      bus.upd_target = is_br ? bus.BranchTarget : pc_plus4;
    end
  end

  // Redirect is owed on a fresh miss or while a stalled one is pending; the newest miss wins.
  always_comb begin
    redirect_w      = miss | (state_q == PEND);
    bus.redirect    = redirect_w;
    bus.flush_req   = redirect_w;
    bus.redirect_pc = '0;
    if (miss) begin
      bus.redirect_pc = miss_tgt;
    end else if (state_q == PEND) begin
      bus.redirect_pc = pend_pc_q;
    end
  end

  // Saturating statistics counters advance only on a resolve.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (resolve && is_br && !(&br_cnt_q)) begin
      br_cnt_d = br_cnt_q + CNT_ONE;
    end
    if (miss && !(&miss_cnt_q)) begin
      miss_cnt_d = miss_cnt_q + CNT_ONE;
    end
  end

  assign bus.br_cnt   = br_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;

  // Pipeline prediction registers and statistics state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q        <= '0;
      e_q        <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      d_q        <= d_d;
      e_q        <= e_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Redirect FSM: park the target while fetch is stalled, release on the first un-stalled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss && bus.StallF) begin
            state_q   <= PEND;
            pend_pc_q <= miss_tgt;
          end
        end
        PEND: begin
          if (miss) begin
            pend_pc_q <= miss_tgt;
          end
          if (!bus.StallF) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Purpose: checks branch_resolve_unit against directed scenarios and a behavioural model under random stimulus.
// Latency: outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// Backpressure: stall/flush controls are driven directly, both directed and random.
module tb_branch_resolve_unit;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam logic [31:0] PCS [4] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0340, 32'hFFFF_FFFC};

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();
  branch_resolve_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush_req;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic             upd_taken;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;
  } obs_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tg;
  } entry_t;

  // Reference model: in-flight predictions, an owed redirect, plain integer counts.
  entry_t      m_d, m_e;
  logic        m_owed;
  logic [31:0] m_owed_pc;
  int          m_br, m_miss;

  // Apply the outcome rules to an EX entry: {miss, corrected target}.
  function automatic logic [32:0] classify(entry_t e);
    logic br;
    br = (bus.BranchTypeE != 3'd0);
    if (br && !e.pt && bus.BranchE)                         return {1'b1, bus.BranchTarget};
    if (br && e.pt && !bus.BranchE)                         return {1'b1, e.pc + 32'd4};
    if (br && e.pt && bus.BranchE && e.tg != bus.BranchTarget) return {1'b1, bus.BranchTarget};
    if (!br && e.pt)                                        return {1'b1, e.pc + 32'd4};
    return 33'd0;
  endfunction

  function automatic logic miss_now();
    logic [32:0] c;
    c = classify(m_e);
    return m_e.vld && !bus.StallE && c[32];
  endfunction

  function automatic logic [31:0] tgt_now();
    logic [32:0] c;
    c = classify(m_e);
    return c[31:0];
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    logic r;
    o = '0;
    r = m_e.vld && !bus.StallE;
    if (r && (bus.BranchTypeE != 3'd0 || m_e.pt)) begin
      o.upd_valid = 1'b1;
      o.upd_pc    = m_e.pc;
      if (bus.BranchTypeE != 3'd0) begin
        o.upd_taken  = bus.BranchE;
        o.upd_target = bus.BranchTarget;
      end else begin
        o.upd_target = m_e.pc + 32'd4;
      end
    end
    if (miss_now()) begin
      o.redirect    = 1'b1;
      o.redirect_pc = tgt_now();
    end else if (m_owed) begin
      o.redirect    = 1'b1;
      o.redirect_pc = m_owed_pc;
    end
    o.flush_req = o.redirect;
    o.br_cnt    = CNT_W'(m_br);
    o.miss_cnt  = CNT_W'(m_miss);
    return o;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.redirect    = bus.redirect;
    o.redirect_pc = bus.redirect_pc;
    o.flush_req   = bus.flush_req;
    o.upd_valid   = bus.upd_valid;
    o.upd_pc      = bus.upd_pc;
    o.upd_target  = bus.upd_target;
    o.upd_taken   = bus.upd_taken;
    o.br_cnt      = bus.br_cnt;
    o.miss_cnt    = bus.miss_cnt;
    return o;
  endfunction

  // Advance the reference model on each edge; a redirect stays owed while fetch is stalled.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d       <= '0;
      m_e       <= '0;
      m_owed    <= 1'b0;
      m_owed_pc <= '0;
      m_br      <= 0;
      m_miss    <= 0;
    end else begin
      if (!bus.StallD) begin
        if (bus.FlushD) m_d <= '0;
        else            m_d <= {1'b1, bus.PCF, bus.pred_taken_F, bus.pred_target_F};
      end
      if (!bus.StallE) m_e <= bus.FlushE ? '0 : m_d;
      if (m_e.vld && !bus.StallE && bus.BranchTypeE != 3'd0) m_br <= (m_br < MAXC) ? m_br + 1 : MAXC;
      if (miss_now()) begin
        m_miss    <= (m_miss < MAXC) ? m_miss + 1 : MAXC;
        m_owed_pc <= tgt_now();
      end
      m_owed <= bus.StallF && (m_owed || miss_now());
    end
  end

  task automatic set_ex(input logic [2:0] t, input logic b, input logic [31:0] tg);
    bus.BranchTypeE  = t;
    bus.BranchE      = b;
    bus.BranchTarget = tg;
  endtask

  task automatic idle_inputs();
    bus.PCF = '0; bus.pred_taken_F = 1'b0; bus.pred_target_F = '0;
    bus.StallF = 1'b0; bus.StallD = 1'b0; bus.StallE = 1'b0;
    bus.FlushD = 1'b0; bus.FlushE = 1'b0;
    set_ex(3'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Fetch one prediction and walk it into EX; a not-predicted filler follows it.
  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
    bus.PCF = pc; bus.pred_taken_F = pt; bus.pred_target_F = tg;
    set_ex(3'd0, 1'b0, 32'd0);
    @(posedge clk); #1;
    bus.PCF = pc + 32'h1000; bus.pred_taken_F = 1'b0; bus.pred_target_F = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (observed() !== obs_t'(0)) begin
      errors++; $display("FAIL reset_async: got %h expected 0", observed());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (observed() !== obs_t'(0)) begin
      errors++; $display("FAIL reset_held: got %h expected 0", observed());
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_correct_pred();
    do_reset();
    push(32'h100, 1'b1, 32'h200);
    set_ex(3'd1, 1'b1, 32'h200);
    @(negedge clk);
    checks++;
    if (bus.redirect !== 1'b0 || bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h100 ||
        bus.upd_taken !== 1'b1 || bus.upd_target !== 32'h200) begin
      errors++;
      $display("FAIL correct_pred: redirect=%0b upd_valid=%0b upd_pc=%h upd_taken=%0b upd_target=%h, expected 0 1 00000100 1 00000200",
               bus.redirect, bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_target);
    end
    @(posedge clk); #1;
    set_ex(3'd0, 1'b0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.br_cnt !== 4'd1 || bus.miss_cnt !== 4'd0 || bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL correct_pred_cnt: br_cnt=%0d miss_cnt=%0d upd_valid=%0b, expected 1 0 0", bus.br_cnt, bus.miss_cnt, bus.upd_valid);
    end
  endtask

  task automatic test_not_taken_miss();
    do_reset();
    push(32'h40, 1'b1, 32'h80);
    set_ex(3'd2, 1'b0, 32'h80);
    @(negedge clk);
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h44 || bus.flush_req !== 1'b1 ||
        bus.upd_valid !== 1'b1 || bus.upd_taken !== 1'b0) begin
      errors++;
      $display("FAIL not_taken_miss: redirect=%0b pc=%h flush=%0b upd_valid=%0b upd_taken=%0b, expected 1 00000044 1 1 0",
               bus.redirect, bus.redirect_pc, bus.flush_req, bus.upd_valid, bus.upd_taken);
    end
    @(posedge clk); #1;
    set_ex(3'd0, 1'b0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.miss_cnt !== 4'd1 || bus.redirect !== 1'b0) begin
      errors++; $display("FAIL not_taken_cnt: miss_cnt=%0d redirect=%0b, expected 1 0", bus.miss_cnt, bus.redirect);
    end
    // Fall-through past the top of the address space wraps to zero.
    push(32'hFFFF_FFFC, 1'b1, 32'h10);
    set_ex(3'd1, 1'b0, 32'h10);
    @(negedge clk);
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0) begin
      errors++; $display("FAIL pc_wrap: redirect=%0b pc=%h, expected 1 00000000", bus.redirect, bus.redirect_pc);
    end
    @(posedge clk); #1;
    set_ex(3'd0, 1'b0, 32'd0);
  endtask

  task automatic test_wrong_target_alias();
    do_reset();
    push(32'h80, 1'b1, 32'h300);
    set_ex(3'd1, 1'b1, 32'h340);
    @(negedge clk);
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h340 || bus.upd_target !== 32'h340 || bus.upd_taken !== 1'b1) begin
      errors++;
      $display("FAIL wrong_target: redirect=%0b pc=%h upd_target=%h upd_taken=%0b, expected 1 00000340 00000340 1",
               bus.redirect, bus.redirect_pc, bus.upd_target, bus.upd_taken);
    end
    @(posedge clk); #1;
    push(32'h90, 1'b1, 32'h500);
    set_ex(3'd0, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h94 || bus.upd_valid !== 1'b1 ||
        bus.upd_pc !== 32'h90 || bus.upd_taken !== 1'b0 || bus.upd_target !== 32'h94) begin
      errors++;
      $display("FAIL alias: redirect=%0b pc=%h upd_valid=%0b upd_pc=%h upd_taken=%0b upd_target=%h, expected 1 00000094 1 00000090 0 00000094",
               bus.redirect, bus.redirect_pc, bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_target);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.br_cnt !== 4'd1 || bus.miss_cnt !== 4'd2) begin
      errors++; $display("FAIL alias_cnt: br_cnt=%0d miss_cnt=%0d, expected 1 2", bus.br_cnt, bus.miss_cnt);
    end
  endtask

  task automatic test_stall_flush();
    int pulses;
    do_reset();
    bus.PCF = 32'h40; bus.pred_taken_F = 1'b1; bus.pred_target_F = 32'h80;
    @(posedge clk); #1;
    bus.PCF = 32'h60; bus.pred_taken_F = 1'b0; bus.pred_target_F = '0;
    bus.FlushE = 1'b1;
    set_ex(3'd1, 1'b0, 32'h80);
    @(posedge clk); #1;
    bus.FlushE = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.redirect !== 1'b0 || bus.upd_valid !== 1'b0) begin
      errors++; $display("FAIL flushE_bubble: redirect=%0b upd_valid=%0b, expected 0 0", bus.redirect, bus.upd_valid);
    end
    // Mispredict held in EX for 3 cycles: exactly one update when released.
    do_reset();
    push(32'h40, 1'b1, 32'h80);
    bus.StallE = 1'b1; bus.StallD = 1'b1;
    set_ex(3'd1, 1'b0, 32'h80);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.upd_valid === 1'b1 || bus.redirect === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== 0 || bus.miss_cnt !== 4'd0) begin
      errors++; $display("FAIL stallE_hold: active_cycles=%0d miss_cnt=%0d, expected 0 0", pulses, bus.miss_cnt);
    end
    bus.StallE = 1'b0; bus.StallD = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h44) begin
      errors++; $display("FAIL stallE_release: upd_valid=%0b redirect=%0b pc=%h, expected 1 1 00000044", bus.upd_valid, bus.redirect, bus.redirect_pc);
    end
    @(posedge clk); #1;
    set_ex(3'd0, 1'b0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.miss_cnt !== 4'd1 || bus.upd_valid !== 1'b0) begin
      errors++; $display("FAIL stallE_single: miss_cnt=%0d upd_valid=%0b, expected 1 0", bus.miss_cnt, bus.upd_valid);
    end
  endtask

  task automatic test_pend();
    do_reset();
    push(32'h40, 1'b1, 32'h80);
    bus.StallF = 1'b1;
    set_ex(3'd1, 1'b0, 32'h80);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h44 || bus.flush_req !== 1'b1) begin
        errors++; $display("FAIL pend_cycle%0d: redirect=%0b pc=%h flush=%0b, expected 1 00000044 1", i, bus.redirect, bus.redirect_pc, bus.flush_req);
      end
      @(posedge clk); #1;
      set_ex(3'd0, 1'b0, 32'd0);
    end
    bus.StallF = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h44) begin
      errors++; $display("FAIL pend_release: redirect=%0b pc=%h, expected 1 00000044", bus.redirect, bus.redirect_pc);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      errors++; $display("FAIL pend_idle: redirect=%0b pc=%h, expected 0 00000000", bus.redirect, bus.redirect_pc);
    end
    // Reset in the middle of a pending redirect drops it without a clock edge.
    do_reset();
    push(32'h40, 1'b1, 32'h80);
    bus.StallF = 1'b1;
    set_ex(3'd1, 1'b0, 32'h80);
    @(posedge clk); #1;
    set_ex(3'd0, 1'b0, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.redirect !== 1'b0 || bus.flush_req !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      errors++; $display("FAIL pend_async_rst: redirect=%0b flush=%0b pc=%h, expected 0 0 00000000", bus.redirect, bus.flush_req, bus.redirect_pc);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.StallF = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.pred_taken_F  = 1'b1;
    bus.pred_target_F = 32'h500;
    set_ex(3'd3, 1'b0, 32'h0);
    for (int i = 0; i < 22; i++) begin
      bus.PCF = 32'(i * 4);
      @(posedge clk); #1;
      if (i == 9) begin
        checks++;
        if (bus.br_cnt !== 4'd8 || bus.miss_cnt !== 4'd8) begin
          errors++; $display("FAIL sat_partial: br_cnt=%0d miss_cnt=%0d, expected 8 8", bus.br_cnt, bus.miss_cnt);
        end
      end
    end
    checks++;
    if (bus.br_cnt !== 4'd15 || bus.miss_cnt !== 4'd15) begin
      errors++; $display("FAIL saturation: br_cnt=%0d miss_cnt=%0d, expected 15 15", bus.br_cnt, bus.miss_cnt);
    end
    bus.pred_taken_F = 1'b0;
  endtask

  task automatic test_random();
    obs_t exp, got;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst                = ($urandom_range(0, 199) == 0);
      bus.PCF            = PCS[$urandom_range(0, 3)];
      bus.pred_taken_F   = ($urandom_range(0, 1) == 1);
      bus.pred_target_F  = PCS[$urandom_range(0, 3)];
      bus.StallF         = ($urandom_range(0, 9) < 4);
      bus.StallD         = ($urandom_range(0, 9) < 2);
      bus.StallE         = ($urandom_range(0, 9) < 2);
      bus.FlushD         = ($urandom_range(0, 9) < 1);
      bus.FlushE         = ($urandom_range(0, 9) < 1);
      bus.BranchTypeE    = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      bus.BranchE        = ($urandom_range(0, 1) == 1);
      bus.BranchTarget   = PCS[$urandom_range(0, 3)];
      @(negedge clk);
      exp = model_out();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_correct_pred();
    test_not_taken_miss();
    test_wrong_target_alias();
    test_stall_flush();
    test_pend();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution and recovery unit: the consuming end of the fetch-stage branch predictor. It carries each fetched instruction's prediction (taken bit and predicted target) down the IF→ID→EX pipeline registers alongside the pipeline's own stall/flush controls. In EX it compares the prediction against the actual outcome and issues a redirect with its correct PC, plus a flush request and a predictor update request. It also keeps saturating branch and mispredict statistics counters.

## Interface
- CNT_W, 32: width of statistics counters.
- clk  in  1  core clock; all state on posedge.
- rst  in  1  reset, asynchronous and active-high.
- PCF  in  32  fetch-stage PC.
- pred_taken_F  in  1  predictor chose the taken path for PCF.
- pred_target_F  in  32  predicted target for PCF (meaningful only when pred_taken_F=1).
- StallF, StallD, StallE  in  1  stage hold controls from hazard unit.
- FlushD, FlushE  in  1  stage bubble-insert controls from hazard unit.
- BranchTypeE  in  3  branch type of EX instruction; 0 = not a branch.
- BranchE  in  1  actual taken outcome of EX branch.
- BranchTarget  in  32  actual target of EX branch.
- redirect  out  1  fetch must load redirect_pc.
- redirect_pc  out  32  corrected fetch PC.
- flush_req  out  1  request FlushD/FlushE (wrong-path squash); equal to redirect.
- upd_valid  out  1  one-cycle predictor write strobe.
- upd_pc, upd_target  out  32  PC and target to write.
- upd_taken  out  1  outcome to record.
- br_cnt, miss_cnt  out  CNT_W  resolved branches / mispredicts.

## Operation
- Pipeline registers {valid, pc, ptaken, ptarget} at D and E. On !StallD: D ← FlushD ? all-zero : {1, PCF, pred_taken_F, pred_target_F}. On !StallE: E ← FlushE ? all-zero : D. Stalled stages hold.
- Resolve event R = validE & !StallE. Nothing is evaluated on a bubble or while EX is held.
- Outcome classes at R (br = BranchTypeE≠0):
  - br, ptaken=0, BranchE=1: miss, target BranchTarget.
  - br, ptaken=1, BranchE=0: miss, target pcE+4.
  - br, ptaken=1, BranchE=1, ptarget≠BranchTarget: miss, target BranchTarget.
  - !br, ptaken=1 (alias hit): miss, target pcE+4.
  - otherwise: correct, no redirect.
- Update at R: upd_valid=1 if br or (!br & ptaken). upd_pc=pcE. For br: upd_target=BranchTarget, upd_taken=BranchE. For the alias case: upd_taken=0, upd_target=pcE+4.
- Counters at R: br_cnt+=1 if br; miss_cnt+=1 on any miss. Both saturate at all-ones and do not wrap.
- Redirect FSM, states IDLE and PEND:
  - IDLE: a miss at R with StallF=0 gives redirect=1 combinationally that cycle, redirect_pc = computed target.
  - IDLE: a miss at R with StallF=1 latches target into pend_pc and moves to PEND. redirect=1 is also driven in that cycle.
  - PEND: redirect=1, redirect_pc=pend_pc. Return to IDLE on the first edge with StallF=0.
  - PEND with a new miss at R: pend_pc is overwritten by the newer target. The newer target wins, because the younger miss is already on the correct path of the older one only if the older was flushed; the hazard unit guarantees EX holds only correct-path instructions.
- flush_req = redirect.
- pc+4 arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 = 0.

## Timing
- Reset: all pipeline regs 0, FSM IDLE, pend_pc 0, counters 0. Outputs: redirect=0, redirect_pc=0, flush_req=0, upd_valid=0, upd_pc/upd_target/upd_taken=0, br_cnt=miss_cnt=0.
- Prediction latency: fetch to EX takes 2 un-stalled edges. Resolution outputs are combinational in the EX cycle.
- upd_valid is exactly one cycle per R. It never asserts while StallE=1.
- Counters reflect a resolution on the edge ending that R cycle.
- Simultaneous StallD & FlushD: stall wins (hold). Same rule for StallE & FlushE.
- Reset asserted mid-PEND: returns to IDLE immediately and redirect drops asynchronously.

## Test plan
- Correct prediction: fetch PC 0x100 with pred_taken_F=1 and target 0x200; in EX, BranchTypeE=1, BranchE=1, BranchTarget=0x200 → redirect=0; upd_valid=1, upd_pc=0x100, upd_taken=1; br_cnt=1, miss_cnt=0.
- Not-taken mispredict: PC 0x40 predicted taken, BranchE=0 → redirect=1, redirect_pc=0x44, flush_req=1, upd_taken=0, miss_cnt=1.
- Wrong target plus alias: (a) PC 0x80 predicted taken to 0x300, actual 0x340 → redirect_pc=0x340. (b) A non-branch at 0x90 predicted taken → redirect_pc=0x94, upd_taken=0, br_cnt unchanged.
- Stall/flush gating: FlushE while a predicted-taken entry moves to EX → no redirect, no update. StallE held 3 cycles on a mispredict → single upd_valid pulse when the stall releases.
- PEND: miss at 0x40 (target 0x44) with StallF=1 for 4 cycles → redirect=1, redirect_pc=0x44 on all 4 cycles; FSM returns to IDLE on the edge StallF=0. rst pulsed during PEND → redirect=0 at once.
- Saturation: CNT_W=4 with 20 mispredicts → br_cnt=miss_cnt=15.
